// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   BYTE_W       width of one transmitted byte
//   REQ0 / REQ1  requester indices into slot and grant vectors
//   arb_state_e  arbiter states (IDLE, SEND, GUARD)
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_req_slot.sv
// One-entry holding register for a requester byte.
//   clk, rst_n   system clock, async active-low reset
//   load         capture data_in/last_in and mark the slot full
//   clear        mark the slot empty (byte handed to the transmitter)
//   data_in      byte to capture
//   last_in      byte ends its frame
//   valid        slot holds a byte
//   data, last   held byte and its end-of-frame flag
module uart_req_slot
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              last_in,
    output logic              valid,
    output logic [BYTE_W-1:0] data,
    output logic              last
);

    // load only happens into an empty slot and clear only from a full one,
    // so the two never coincide in practice; load wins if they ever do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            last  <= last_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte-stream requesters.
// Each requester has a one-entry slot; the arbiter picks round-robin or
// fixed-priority and can hold the grant for a whole frame.
//   clk, rst_n                     system clock, async active-low reset
//   reqN_valid/data/last/ready     requester N byte handshake (N = 0, 1)
//   tx_rdy                         transmitter idle
//   tx_en                          one-cycle start pulse to transmitter
//   tx_data                        byte to transmitter, held until next send
//   grant                          one-hot current owner, 00 when none
//   busy                           not IDLE, or a frame lock is held
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for tx_rdy and an eligible slot
// ST_SEND  | tx_en high for this single cycle
// ST_GUARD | GUARD_CYCLES cycles with tx_rdy ignored
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int LOCK_FRAMES  = 1,
    parameter int PRIO_FIXED   = 0,
    parameter int GUARD_CYCLES = 2,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [BYTE_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BYTE_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    input  logic              tx_rdy,
    output logic              tx_en,
    output logic [BYTE_W-1:0] tx_data,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int              TO_W       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [3:0]      GUARD_LOAD = 4'(GUARD_CYCLES - 1);
    localparam logic            FIXED_EN   = (PRIO_FIXED != 0);
    localparam logic            LOCK_EN    = (LOCK_FRAMES != 0);
    localparam logic            TO_EN      = (LOCK_TIMEOUT != 0);

    arb_state_e        state;
    logic [3:0]        guard_cnt;
    logic              lock;
    logic              owner;
    logic              rr_ptr;
    logic [TO_W-1:0]   to_cnt;

    logic [1:0]        slot_valid;
    logic [1:0]        slot_last;
    logic [1:0]        slot_load;
    logic [1:0]        slot_clear;
    logic [BYTE_W-1:0] slot_data [2];

    logic [1:0]        eligible;
    logic              decide;
    logic              pick;
    logic [1:0]        pick_oh;
    logic              timeout_hit;

    assign slot_load[REQ0] = req0_valid & ~slot_valid[REQ0];
    assign slot_load[REQ1] = req1_valid & ~slot_valid[REQ1];
    assign req0_ready      = ~slot_valid[REQ0];
    assign req1_ready      = ~slot_valid[REQ1];

    uart_req_slot u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (slot_load[REQ0]),
        .clear   (slot_clear[REQ0]),
        .data_in (req0_data),
        .last_in (req0_last),
        .valid   (slot_valid[REQ0]),
        .data    (slot_data[REQ0]),
        .last    (slot_last[REQ0])
    );

    uart_req_slot u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (slot_load[REQ1]),
        .clear   (slot_clear[REQ1]),
        .data_in (req1_data),
        .last_in (req1_last),
        .valid   (slot_valid[REQ1]),
        .data    (slot_data[REQ1]),
        .last    (slot_last[REQ1])
    );

    // While locked only the owner may send; the other side waits even if full.
    assign eligible[REQ0] = slot_valid[REQ0] & (~lock | ~owner);
    assign eligible[REQ1] = slot_valid[REQ1] & (~lock |  owner);
    assign decide         = (state == ST_IDLE) & tx_rdy & (|eligible);

    // Tie-break: requester 0 under fixed priority, else whoever rr_ptr favours.
    assign pick       = eligible[REQ1] & (~eligible[REQ0] | (~FIXED_EN & rr_ptr));
    assign pick_oh    = pick ? 2'b10 : 2'b01;
    assign slot_clear = decide ? pick_oh : 2'b00;

    // An owner byte arriving on the terminal cycle keeps the lock alive.
    assign timeout_hit = TO_EN & lock & (state == ST_IDLE) & ~slot_valid[owner]
                       & ~slot_load[owner] & (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
            lock      <= 1'b0;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            grant     <= 2'b00;
            tx_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (decide) begin
                        state   <= ST_SEND;
                        tx_data <= slot_data[pick];
                        grant   <= pick_oh;
                        if (LOCK_EN && !slot_last[pick]) begin
                            lock  <= 1'b1;
                            owner <= pick;
                        end else begin
                            lock   <= 1'b0;
                            rr_ptr <= ~pick;
                        end
                    end else if (timeout_hit) begin
                        lock   <= 1'b0;
                        rr_ptr <= ~owner;
                        grant  <= 2'b00;
                    end
                end
                ST_SEND: begin
                    state     <= ST_GUARD;
                    guard_cnt <= GUARD_LOAD;
                end
                ST_GUARD: begin
                    if (guard_cnt == 4'd0) begin
                        state <= ST_IDLE;
                        if (!lock) begin
                            grant <= 2'b00;
                        end
                    end else begin
                        guard_cnt <= guard_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!TO_EN || !lock || slot_load[owner] || timeout_hit) begin
            to_cnt <= '0;
        end else if ((state == ST_IDLE) && !slot_valid[owner]) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign tx_en = (state == ST_SEND);
    assign busy  = (state != ST_IDLE) | lock;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART Transmitter between two byte-stream requesters.
- Example pairing: requester 0 is the passthrough path, requester 1 is locally generated status or response bytes.
- Each requester gets a one-entry holding slot. The block arbitrates round-robin or fixed-priority, and can lock the grant for a whole frame so multi-byte messages are never interleaved.
- It drives the Transmitter's rdy/en/data_tx handshake.

Parameters:
- LOCK_FRAMES, 1: when 1, the grant is held by a requester until its byte flagged last has been sent. When 0, arbitration is per byte.
- PRIO_FIXED, 0: 0 selects round-robin. 1 makes requester 0 always win ties.
- GUARD_CYCLES, 2: cycles after each tx_en during which tx_rdy is ignored. Range 1..15.
- LOCK_TIMEOUT, 65535: cycles a locked owner's slot may stay empty before the lock is forcibly released. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 byte available
- req0_data  in  8  requester 0 byte
- req0_last  in  1  byte ends the requester 0 frame
- req0_ready  out  1  requester 0 slot empty
- req1_valid  in  1  requester 1 byte available
- req1_data  in  8  requester 1 byte
- req1_last  in  1  byte ends the requester 1 frame
- req1_ready  out  1  requester 1 slot empty
- tx_rdy  in  1  Transmitter idle
- tx_en  out  1  one-cycle start pulse to Transmitter
- tx_data  out  8  byte to Transmitter
- grant  out  2  one-hot current owner, 00 when none
- busy  out  1  state is not IDLE, or lock is held

Behaviour:
- Reset (async, rst_n=0) values:
  - tx_en=0, tx_data=0, grant=00, busy=0.
  - Both slots empty, so reqN_ready=1 while in reset.
  - lock cleared; the round-robin pointer favours requester 0; state IDLE; timeout counter 0.
  - Any byte in flight or held in a slot is discarded. A frame cut by reset is not resumed.
- Slots:
  - reqN_ready = ~slotN_valid. There is no bypass, so load and drain of the same slot never coincide.
  - On a clock edge with reqN_valid & reqN_ready, the slot captures data and last.
- FSM states: IDLE, SEND, GUARD.
- IDLE:
  - Condition to move on: tx_rdy=1 and an eligible slot is valid.
  - If locked, only the lock owner is eligible. The other requester waits even when it holds data.
  - If unlocked and both slots are valid: with PRIO_FIXED=1 requester 0 wins; otherwise the requester not served last wins.
  - With one valid slot, that slot wins.
  - Transition to SEND. In the same edge: register tx_data, set grant, clear the chosen slot, and update lock and pointer.
- SEND: tx_en=1 for exactly this one cycle, then go to GUARD.
- GUARD: count GUARD_CYCLES cycles with tx_rdy ignored, then return to IDLE.
- tx_data holds its value until the next SEND.
- Latency with the bus idle:
  - A byte accepted at edge k is in its slot after edge k.
  - The arbiter decides at edge k+1, so tx_en is high between edges k+1 and k+2.
  - Minimum spacing between tx_en pulses is 2+GUARD_CYCLES cycles. In practice it is set by tx_rdy.
- Lock (LOCK_FRAMES=1):
  - Sending a byte with last=0 sets lock with owner = sender.
  - Sending the owner's byte with last=1 clears lock and moves the round-robin pointer to the other requester.
  - With LOCK_FRAMES=0 the pointer moves after every byte and lock never sets.
- grant:
  - Updates on each decision.
  - Clears to 00 when the block returns to IDLE with no lock.
  - Stays at the owner's bit while locked.
- Lock timeout (LOCK_TIMEOUT>0):
  - The counter runs while locked, the FSM is in IDLE and the owner's slot is empty.
  - The counter resets whenever the owner's slot loads.
  - When the counter reaches LOCK_TIMEOUT, lock clears, the pointer moves to the other requester, and grant clears to 00.
  - A later byte from the old owner is treated as the start of a new frame.
- Simultaneous events:
  - A new load into the other slot during SEND or GUARD is fine.
  - If tx_rdy drops during IDLE, no decision is made.

Decomposition:
- Shared package uart_pkg holds:
  - the BYTE_W=8 constant;
  - the arbiter state enum (IDLE/SEND/GUARD);
  - the requester index constants REQ0=0, REQ1=1.
- One sub-module, uart_req_slot: the one-entry valid/data/last holding register with load and clear inputs. It is instantiated twice.

Test Plan:
- Single byte: tx_rdy=1, req0 sends 0x41 last=1 → exactly one tx_en pulse, tx_data=0x41, 2 cycles after accept; grant=01, then 00.
- Contention: LOCK_FRAMES=0, PRIO_FIXED=0; both slots loaded repeatedly with 0x10.. on req0 and 0x20.. on req1 → tx_data alternates 0x10,0x20,0x11,0x21; no pulse spacing below 2+GUARD_CYCLES.
- Frame lock: req0 frame 0x01,0x02,0x03 (last on 0x03) with req1 holding 0x55 throughout → 0x55 is emitted only after 0x03; grant stays 01 until then.
- Fixed priority: PRIO_FIXED=1, both slots permanently valid → only req0 bytes are sent while req0 keeps its slot full.
- Lock timeout: LOCK_TIMEOUT=8; req0 sends 0x01 last=0, then goes silent while req1 holds 0x77 → lock releases after 8 idle cycles and 0x77 is sent.
- Reset mid-frame: assert rst_n=0 during GUARD with both slots full → tx_en, grant and busy are 0 immediately, both ready=1; after release no stale byte is sent.
